// File: rtl/uart_tx_report.sv
// Renders a DATA_W-bit word as uppercase ASCII hex (MS nibble first), optionally followed by
// CR LF, and shifts the characters out 8N1 on uart_tx using an internal baud counter.
module uart_tx_report #(
  parameter int CLK_FRE    = 10,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_W     = 20,
  parameter int APPEND_EOL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              uart_tx,
  output logic              busy,
  output logic              done
);
  localparam int CYCLE = CLK_FRE * 1_000_000 / BAUD_RATE;
  localparam int NCHAR = DATA_W / 4;
  localparam int LAST  = (APPEND_EOL != 0) ? NCHAR + 1 : NCHAR - 1;
  localparam int IDX_W = $clog2(NCHAR + 2);
  localparam int CNT_W = (CYCLE > 1) ? $clog2(CYCLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_baud_cnt;
  logic [2:0]        r_bit_cnt;
  logic [IDX_W-1:0]  r_char_idx;
  logic [DATA_W-1:0] r_shadow;
  logic [7:0]        r_shift;
  logic [7:0]        w_char;
  logic [3:0]        w_nib;
  logic              r_tx;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              w_tx;
  logic              w_done;
  logic              w_accept;
  logic              w_baud_end;
  logic              w_last;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign w_accept   = tx_valid & r_ready & (r_state == S_IDLE);
  assign w_baud_end = (r_baud_cnt == CNT_W'(CYCLE - 1));
  assign w_last     = (r_char_idx == IDX_W'(LAST));

  always_comb begin
    w_nib = 4'h0;
    for (int i = 0; i < NCHAR; i++) begin
      if (r_char_idx == IDX_W'(i)) w_nib = r_shadow[DATA_W-1-4*i -: 4];
    end
    if (r_char_idx < IDX_W'(NCHAR))       w_char = hex_ascii(w_nib);
    else if (r_char_idx == IDX_W'(NCHAR)) w_char = 8'h0D;
    else                                  w_char = 8'h0A;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx        = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_START;
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_baud_end) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_baud_end && (r_bit_cnt == 3'd7)) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_baud_end) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
          end else begin
            w_state_nxt = S_START;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Line level follows the current state one clock later, so the start bit lags accept by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx    <= 1'b1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tx    <= w_tx;
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_char_idx <= '0;
      r_shadow   <= '0;
    end else begin
      if ((r_state == S_IDLE) || w_baud_end) r_baud_cnt <= '0;
      else                                   r_baud_cnt <= r_baud_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shadow   <= tx_data;
            r_char_idx <= '0;
          end
        end
        S_START: begin
          if (w_baud_end) r_bit_cnt <= '0;
        end
        S_DATA: begin
          if (w_baud_end) r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        S_STOP: begin
          if (w_baud_end && !w_last) r_char_idx <= r_char_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_START) && w_baud_end)     r_shift <= w_char;
    else if ((r_state == S_DATA) && w_baud_end) r_shift <= {1'b0, r_shift[7:1]};
  end

  assign tx_ready = r_ready;
  assign uart_tx  = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_uart_tx_report.sv
// Bench for uart_tx_report: default, no-EOL and slow-baud instances checked against a
// line decoder and a hex-string reference model.
module tb_uart_tx_report;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [19:0] data_a = '0, data_b = '0, data_c = '0;
  logic valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
  logic ready_a, ready_b, ready_c, tx_a, tx_b, tx_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;

  uart_tx_report dut_a (.clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .uart_tx(tx_a), .busy(busy_a), .done(done_a));
  uart_tx_report #(.APPEND_EOL(0)) dut_b (.clk(clk), .rst(rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .uart_tx(tx_b), .busy(busy_b), .done(done_b));
  uart_tx_report #(.CLK_FRE(50), .BAUD_RATE(9600)) dut_c (.clk(clk), .rst(rst), .tx_data(data_c),
    .tx_valid(valid_c), .tx_ready(ready_c), .uart_tx(tx_c), .busy(busy_c), .done(done_c));

  int total = 0;
  int bad = 0;
  int dn_a = 0, dn_b = 0, dcyc_a = 0, dcyc_b = 0;
  logic [7:0] exp_q[$];
  logic [7:0] t2_exp [0:6] = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h33, 8'h0D, 8'h0A};

  always @(negedge clk) begin
    if (done_a === 1'b1) begin dn_a <= dn_a + 1; dcyc_a <= cyc; end
    if (done_b === 1'b1) begin dn_b <= dn_b + 1; dcyc_b <= cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input int sel);
    case (sel)
      0:       return tx_a;
      1:       return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return ready_a;
      1:       return ready_b;
      default: return ready_c;
    endcase
  endfunction

  task automatic drive(input int sel, input logic [19:0] w, input logic v);
    case (sel)
      0:       begin data_a = w; valid_a = v; end
      1:       begin data_b = w; valid_b = v; end
      default: begin data_c = w; valid_c = v; end
    endcase
  endtask

  // Expected character stream: five hex digits, most significant first, then optional CR LF.
  task automatic model(input logic [19:0] w, input bit eol);
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      int n;
      n = int'((w >> (16 - 4 * i)) & 20'hF);
      exp_q.push_back((n < 10) ? 8'(48 + n) : 8'(55 + n));
    end
    if (eol) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic rx_char(input int sel, input int clen, input string tag,
                         output logic [7:0] ch, output int fcyc);
    int n;
    logic st, sp;
    n = 0;
    while (line(sel) !== 1'b0 && n < 12 * clen) begin
      @(negedge clk);
      n++;
    end
    fcyc = cyc;
    chk({tag, "_start_seen"}, 32'(n < 12 * clen), 32'd1);
    repeat (clen / 2) @(negedge clk);
    st = line(sel);
    for (int b = 0; b < 8; b++) begin
      repeat (clen) @(negedge clk);
      ch[b] = line(sel);
    end
    repeat (clen) @(negedge clk);
    sp = line(sel);
    chk({tag, "_startbit"}, 32'(st), 32'd0);
    chk({tag, "_stopbit"}, 32'(sp), 32'd1);
  endtask

  task automatic rx_run(input int sel, input int from, input int to, input string tag,
                        output int ffirst);
    logic [7:0] ch;
    int f;
    ffirst = 0;
    for (int i = from; i < to; i++) begin
      rx_char(sel, 86, $sformatf("%s_c%0d", tag, i), ch, f);
      if (i == from) ffirst = f;
      chk($sformatf("%s_char%0d", tag, i), 32'(ch), 32'(exp_q[i]));
    end
  endtask

  task automatic send(input int sel, input logic [19:0] w, output int acc);
    int n;
    n = 0;
    while (rdy(sel) !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", 32'(rdy(sel)), 32'd1);
    drive(sel, w, 1'b1);
    @(negedge clk);
    acc = cyc;
    drive(sel, 20'($urandom), 1'b0);
  endtask

  initial begin
    int acc, ff, ff2, d0, lows, f0, r0, f1, n;
    logic [19:0] w1, w2;

    // Reset held for three clocks
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 32'(ready_a), 32'd1);
    chk("ready_after_release_b", 32'(ready_b), 32'd1);

    // Known word 1A2F3 with CR LF
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(t2_exp[i]);
    d0 = dn_a;
    send(0, 20'h1A2F3, acc);
    chk("t2_tx_still_idle", 32'(tx_a), 32'd1);
    chk("t2_busy", 32'(busy_a), 32'd1);
    chk("t2_ready_low", 32'(ready_a), 32'd0);
    rx_run(0, 0, 7, "t2", ff);
    chk("t2_latency", ff - acc, 32'd1);
    repeat (100) @(negedge clk);
    chk("t2_done_count", dn_a - d0, 32'd1);
    chk("t2_done_time", dcyc_a - acc, 32'd6020);
    chk("t2_idle_busy", 32'(busy_a), 32'd0);
    chk("t2_idle_ready", 32'(ready_a), 32'd1);

    // FFFFF without line ending
    model(20'hFFFFF, 1'b0);
    d0 = dn_b;
    send(1, 20'hFFFFF, acc);
    rx_run(1, 0, 5, "t3", ff);
    repeat (100) @(negedge clk);
    chk("t3_done_count", dn_b - d0, 32'd1);
    chk("t3_done_time", dcyc_b - acc, 32'd4300);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_b !== 1'b1) lows++;
    end
    chk("t3_line_quiet", lows, 32'd0);
    chk("t3_busy", 32'(busy_b), 32'd0);

    // tx_valid held high; data changes mid-message; second word follows with no gap
    w1 = 20'($urandom);
    w2 = 20'($urandom);
    model(w1, 1'b1);
    d0 = dn_a;
    data_a = w1;
    valid_a = 1'b1;
    @(negedge clk);
    acc = cyc;
    data_a = 20'($urandom);
    rx_run(0, 0, 1, "t4a", ff);
    data_a = w2;
    rx_run(0, 1, 7, "t4a", ff);
    model(w2, 1'b1);
    rx_run(0, 0, 1, "t4b", ff);
    valid_a = 1'b0;
    chk("t4_done_time", dcyc_a - acc, 32'd6020);
    chk("t4_gap", ff - dcyc_a, 32'd2);
    rx_run(0, 1, 7, "t4b", ff2);
    repeat (200) @(negedge clk);
    chk("t4_done_count", dn_a - d0, 32'd2);
    chk("t4_busy", 32'(busy_a), 32'd0);

    // Random words
    for (int k = 0; k < 2; k++) begin
      w1 = 20'($urandom);
      model(w1, 1'b1);
      d0 = dn_a;
      send(0, w1, acc);
      rx_run(0, 0, 7, $sformatf("rnd%0d", k), ff);
      repeat (100) @(negedge clk);
      chk($sformatf("rnd%0d_done_count", k), dn_a - d0, 32'd1);
      chk($sformatf("rnd%0d_done_time", k), dcyc_a - acc, 32'd6020);
    end

    // Reset during data bit 3 of the third character (that bit is 0 by construction)
    w1 = 20'($urandom);
    w1[11] = 1'b0;
    d0 = dn_a;
    send(0, w1, acc);
    while (cyc < acc + 2104) @(negedge clk);
    chk("t5_bit3_low", 32'(tx_a), 32'd0);
    chk("t5_busy_before", 32'(busy_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tx_after_rst", 32'(tx_a), 32'd1);
    chk("t5_busy_after_rst", 32'(busy_a), 32'd0);
    chk("t5_ready_in_rst", 32'(ready_a), 32'd0);
    chk("t5_done_in_rst", 32'(done_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ready_after", 32'(ready_a), 32'd1);
    repeat (50) @(negedge clk);
    chk("t5_no_done", dn_a - d0, 32'd0);
    chk("t5_line_idle", 32'(tx_a), 32'd1);
    model(20'h00000, 1'b1);
    d0 = dn_a;
    send(0, 20'h00000, acc);
    rx_run(0, 0, 7, "t5", ff);
    repeat (100) @(negedge clk);
    chk("t5_done_count", dn_a - d0, 32'd1);
    chk("t5_done_time", dcyc_a - acc, 32'd6020);

    // 50 MHz / 9600 baud: measure bit periods on line edges (first char '1' = 0x31)
    chk("t6_ready", 32'(ready_c), 32'd1);
    data_c = 20'h10000 | 20'($urandom_range(0, 65535));
    valid_c = 1'b1;
    @(negedge clk);
    valid_c = 1'b0;
    n = 0;
    while (tx_c !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    f0 = cyc;
    chk("t6_busy", 32'(busy_c), 32'd1);
    n = 0;
    while (tx_c !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    r0 = cyc;
    n = 0;
    while (tx_c !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
    f1 = cyc;
    chk("t6_start_period", r0 - f0, 32'd5208);
    chk("t6_bit0_period", f1 - r0, 32'd5208);
    chk("t6_no_done", 32'(done_c), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
